// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and sizing helpers for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Wide enough to hold the larger of the hold and stagger reload values.
  function automatic int cnt_width(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_sync.sv
// rtl/reset_seq_ctrl_sync.sv - multi-flop synchroniser for the async reset request
module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - stretches reset requests and releases NUM_CH domains in order
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 4,
  parameter int STAGGER     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              async_reset_in,
  input  logic              sw_reset_req,
  output logic [NUM_CH-1:0] reset_out,
  output logic              busy,
  output logic              done
);

  localparam int CW  = cnt_width(HOLD_CYC, STAGGER);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0]     HOLD_LOAD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]     STAG_LOAD   = (STAGGER > 0) ? CW'(STAGGER - 1) : CW'(0);
  localparam logic [CHW-1:0]    LAST_CH     = CHW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ALL_ON      = '1;
  localparam logic [NUM_CH-1:0] ONE_BIT     = NUM_CH'(1);
  localparam bit                SINGLE_STEP = (STAGGER == 0) || (NUM_CH == 1);

  logic              sync_req;
  logic              req;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0] reset_q, reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (async_reset_in),
    .q     (sync_req)
  );

  assign req = sync_req | sw_reset_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= HOLD_LOAD;
      ch_q    <= '0;
      reset_q <= ALL_ON;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      reset_q <= reset_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    reset_d = reset_q;
    done_d  = 1'b0;

    if (req) begin
      state_d = ASSERT;
      reset_d = ALL_ON;
    end else begin
      case (state_q)
        IDLE: begin
          reset_d = '0;
        end
        ASSERT: begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          reset_d = ALL_ON;
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (SINGLE_STEP) begin
            reset_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Channel 0 leaves reset on the edge that ends the hold window.
            reset_d = reset_q & ~ONE_BIT;
            ch_d    = CHW'(1);
            cnt_d   = STAG_LOAD;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            reset_d = reset_q & ~(ONE_BIT << ch_q);
            if (ch_q == LAST_CH) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              ch_d  = ch_q + CHW'(1);
              cnt_d = STAG_LOAD;
            end
          end
        end
        default: begin
          state_d = IDLE;
          reset_d = '0;
        end
      endcase
    end

    busy_d = |reset_d;
  end

  assign reset_out = reset_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
